// File: rtl/coin_pulse_driver.sv
// coin_pulse_driver: turns a "return N coins" request into N timed actuator pulses
module coin_pulse_driver #(
  parameter int ON_CYCLES  = 12_500_000,
  parameter int OFF_CYCLES = 12_500_000,
  parameter int CNT_W      = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic             ready,
  output logic             busy,
  output logic             pulse_out,
  output logic [CNT_W-1:0] remaining,
  output logic             done
);
  localparam int MAX_C = ON_CYCLES > OFF_CYCLES ? ON_CYCLES : OFF_CYCLES;
  localparam int TW = $clog2(MAX_C + 1);
  localparam logic [TW-1:0] ON_LD = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LD = TW'(OFF_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, ON, OFF, DONE} state_t;
  state_t state;
  logic [TW-1:0] timer;
  assign ready = state == IDLE;
  assign busy = state == ON || state == OFF;
  assign done = state == DONE;
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
      remaining <= '0;
      pulse_out <= 1'b0;
    end else
      case (state)
        IDLE:
          if (start) begin
            state <= count != '0 ? ON : DONE;
            pulse_out <= count != '0;
            remaining <= count;
            timer <= ON_LD;
          end
        ON:
          if (timer == '0) begin
            state <= OFF;
            pulse_out <= 1'b0;
            remaining <= remaining - 1'b1;
            timer <= OFF_LD;
          end else
            timer <= timer - 1'b1;
        OFF:
          if (timer == '0) begin
            state <= remaining != '0 ? ON : DONE;
            pulse_out <= remaining != '0;
            timer <= ON_LD;
          end else
            timer <= timer - 1'b1;
        DONE: state <= IDLE;
      endcase
endmodule

// File: tb/tb_coin_pulse_driver.sv
// tb_coin_pulse_driver: scoreboard bench; expected per-cycle outputs come from the pulse timing formulas
module tb_coin_pulse_driver;
  logic clk_in = 1'b0;
  logic rst_n0, rst_n1, start0, start1;
  logic [3:0] count0, count1, remaining0, remaining1;
  logic ready0, busy0, pulse_out0, done0;
  logic ready1, busy1, pulse_out1, done1;
  logic [7:0] act0, act1;
  logic [7:0] q0[$], q1[$];
  int vecs = 0;
  int miss = 0;
  localparam logic [7:0] IDLE_E = 8'b0010_0000;
  always #5 clk_in = ~clk_in;
  assign act0 = {pulse_out0, done0, ready0, busy0, remaining0};
  assign act1 = {pulse_out1, done1, ready1, busy1, remaining1};
  coin_pulse_driver #(.ON_CYCLES(3), .OFF_CYCLES(2), .CNT_W(4)) u0 (
    .clk_in(clk_in), .rst_n(rst_n0), .start(start0), .count(count0), .ready(ready0),
    .busy(busy0), .pulse_out(pulse_out0), .remaining(remaining0), .done(done0));
  coin_pulse_driver #(.ON_CYCLES(1), .OFF_CYCLES(1), .CNT_W(4)) u1 (
    .clk_in(clk_in), .rst_n(rst_n1), .start(start1), .count(count1), .ready(ready1),
    .busy(busy1), .pulse_out(pulse_out1), .remaining(remaining1), .done(done1));
  task automatic push_exp(input int n, input int on, input int off, input bit u);
    int p = on + off;
    for (int c = 1; c <= n * p + 2; c++) begin
      logic pl;
      int fin;
      logic [7:0] e;
      pl = 1'b0;
      fin = 0;
      for (int k = 1; k <= n; k++) begin
        if (c >= (k - 1) * p + 1 && c <= (k - 1) * p + on) pl = 1'b1;
        if ((k - 1) * p + on < c) fin++;
      end
      e = {pl, c == n * p + 1, c >= n * p + 2, c <= n * p, 4'(n - fin)};
      if (u) q1.push_back(e);
      else q0.push_back(e);
    end
  endtask
  task automatic test_reset();
    rst_n0 = 1'b0;
    rst_n1 = 1'b0;
    start0 = 1'b1;
    start1 = 1'b1;
    count0 = 4'd5;
    count1 = 4'd5;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_in);
      if (c == 5) begin
        start0 = 1'b0;
        start1 = 1'b0;
        rst_n0 = 1'b1;
        rst_n1 = 1'b1;
      end
      vecs += 2;
      if (act0 !== IDLE_E) begin miss++; $display("FAIL reset0 c%0d: p/d/r/b/rem got %b want %b", c, act0, IDLE_E); end
      if (act1 !== IDLE_E) begin miss++; $display("FAIL reset1 c%0d: p/d/r/b/rem got %b want %b", c, act1, IDLE_E); end
    end
  endtask
  task automatic test_three_pulse();
    logic [7:0] e;
    @(negedge clk_in);
    start0 = 1'b1;
    count0 = 4'd3;
    push_exp(3, 3, 2, 0);
    @(negedge clk_in);
    start0 = 1'b0;
    for (int c = 1; q0.size() > 0; c++) begin
      e = q0.pop_front();
      vecs++;
      if (act0 !== e) begin miss++; $display("FAIL three_pulse c%0d: got %b want %b", c, act0, e); end
      if (q0.size() > 0) @(negedge clk_in);
    end
  endtask
  task automatic test_zero_count();
    logic [7:0] e;
    @(negedge clk_in);
    start0 = 1'b1;
    count0 = 4'd0;
    push_exp(0, 3, 2, 0);
    @(negedge clk_in);
    start0 = 1'b0;
    for (int c = 1; q0.size() > 0; c++) begin
      e = q0.pop_front();
      vecs++;
      if (act0 !== e) begin miss++; $display("FAIL zero_count c%0d: got %b want %b", c, act0, e); end
      if (q0.size() > 0) @(negedge clk_in);
    end
  endtask
  task automatic test_ignore_busy();
    logic [7:0] e;
    @(negedge clk_in);
    start0 = 1'b1;
    count0 = 4'd2;
    push_exp(2, 3, 2, 0);
    @(negedge clk_in);
    start0 = 1'b0;
    for (int c = 1; q0.size() > 0; c++) begin
      e = q0.pop_front();
      vecs++;
      if (act0 !== e) begin miss++; $display("FAIL ignore_busy c%0d: got %b want %b", c, act0, e); end
      start0 = c == 2 || c == 7;
      count0 = 4'd9;
      if (q0.size() > 0) @(negedge clk_in);
    end
    start0 = 1'b0;
  endtask
  task automatic test_mid_reset();
    logic [7:0] e;
    @(negedge clk_in);
    start0 = 1'b1;
    count0 = 4'd5;
    push_exp(5, 3, 2, 0);
    @(negedge clk_in);
    start0 = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      e = q0.pop_front();
      vecs++;
      if (act0 !== e) begin miss++; $display("FAIL mid_reset_pre c%0d: got %b want %b", c, act0, e); end
      if (c < 7) @(negedge clk_in);
    end
    q0.delete();
    #2 rst_n0 = 1'b0;
    #1 vecs++;
    if (act0 !== IDLE_E) begin miss++; $display("FAIL mid_reset_async: got %b want %b", act0, IDLE_E); end
    repeat (2) @(negedge clk_in);
    rst_n0 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_in);
      vecs++;
      if (act0 !== IDLE_E) begin miss++; $display("FAIL mid_reset_post c%0d: got %b want %b", c, act0, IDLE_E); end
    end
  endtask
  task automatic test_back_to_back();
    logic [7:0] e;
    @(negedge clk_in);
    start1 = 1'b1;
    count1 = 4'd15;
    push_exp(15, 1, 1, 1);
    @(negedge clk_in);
    start1 = 1'b0;
    for (int c = 1; q1.size() > 0; c++) begin
      e = q1.pop_front();
      vecs++;
      if (act1 !== e) begin miss++; $display("FAIL max_count c%0d: got %b want %b", c, act1, e); end
      if (q1.size() > 0) @(negedge clk_in);
    end
    start1 = 1'b1;
    count1 = 4'd1;
    push_exp(1, 1, 1, 1);
    @(negedge clk_in);
    start1 = 1'b0;
    for (int c = 1; q1.size() > 0; c++) begin
      e = q1.pop_front();
      vecs++;
      if (act1 !== e) begin miss++; $display("FAIL back_to_back c%0d: got %b want %b", c, act1, e); end
      if (q1.size() > 0) @(negedge clk_in);
    end
  endtask
  initial begin
    test_reset();
    test_three_pulse();
    test_zero_count();
    test_ignore_busy();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
